// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle-loop datapath: default matrix size,
// the locator FSM state type and the (row, col) -> flat bit index mapping.
package rect_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;

    // Set-bit counter saturates here; anything above four is already invalid.
    localparam logic [2:0] CNT_SAT = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Flat bit index of matrix element (r, c); the flip path uses the same mapping.
    function automatic int idx_of(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/rect_locate_if.sv
// Bundle between a matrix-pair source / result consumer and rect_locate.
// Both directions use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low, and ready may depend on nothing but
// the receiver's own state.
// state is a read-only view of the locator FSM for debug and checkers.
interface rect_locate_if
    import rect_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a_in;
    logic [N-1:0]  b_in;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;
    logic          err;
    state_t        state;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, r1, r2, c1, c2, err, state
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, r1, r2, c1, c2, err, state
    );

endinterface

// File: rtl/rect_corner_check.sv
// Combinational validity check for a located rectangle. Takes the (row, col)
// of the first four set bits of a difference matrix in scan order, plus the
// saturating set-bit count, and flags anything that is not exactly one
// non-degenerate rectangle.
module rect_corner_check
    import rect_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int RW  = $clog2(ROWS),
    localparam int CW  = $clog2(COLS)
) (
    input  logic [RW-1:0] p1_r,
    input  logic [CW-1:0] p1_c,
    input  logic [RW-1:0] p2_r,
    input  logic [CW-1:0] p2_c,
    input  logic [RW-1:0] p3_r,
    input  logic [CW-1:0] p3_c,
    input  logic [RW-1:0] p4_r,
    input  logic [CW-1:0] p4_c,
    input  logic [2:0]    cnt,
    output logic          err
);

    // Corners in scan order are (r1,c1), (r1,c2), (r2,c1), (r2,c2).
    always_comb begin
        logic ok;
        ok = (cnt == 3'd4);
        ok = ok && (p1_r < p3_r);
        ok = ok && (p1_c < p2_c);
        ok = ok && (p2_r == p1_r);
        ok = ok && (idx_of(int'(p3_r), int'(p3_c), COLS) == idx_of(int'(p3_r), int'(p1_c), COLS));
        ok = ok && (idx_of(int'(p4_r), int'(p4_c), COLS) == idx_of(int'(p3_r), int'(p2_c), COLS));
        err = !ok;
    end

endmodule

// File: rtl/rect_locate.sv
// Rectangle locator: XORs an original and a flipped matrix and scans the
// difference one bit per cycle to recover the flipped rectangle (r1,r2,c1,c2),
// or flags err when the difference is not a single non-degenerate rectangle.
// Optional macro RECT_LOCATE_EARLY_EXIT_EN: abort the scan with err=1 on the
// cycle the fifth set bit is seen.
module rect_locate
    import rect_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic         clk,
    input  logic         rst_n,
    rect_locate_if.slave bus
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(N);

    state_t        state_q;
    logic [N-1:0]  diff_q;
    logic [IW-1:0] idx_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [2:0]    cnt_q;
    logic [RW-1:0] pr_q [4];
    logic [CW-1:0] pc_q [4];

    logic          in_ready_q;
    logic          out_valid_q;
    logic          err_q;
    logic [RW-1:0] r1_q, r2_q;
    logic [CW-1:0] c1_q, c2_q;

    logic          hit;
    logic          last_bit;
    logic          early_stop;
    logic [2:0]    cnt_n;
    logic [RW-1:0] pr_n [4];
    logic [CW-1:0] pc_n [4];
    logic          chk_err;

    // Next count/corner values including the bit under scan, so the check on
    // entry to DONE already sees the final bit.
    always_comb begin
        hit      = diff_q[idx_q];
        last_bit = (idx_q == IW'(N - 1));
        cnt_n    = (hit && cnt_q != CNT_SAT) ? cnt_q + 3'd1 : cnt_q;
        pr_n     = pr_q;
        pc_n     = pc_q;
        for (int k = 0; k < 4; k++) begin
            if (hit && cnt_q == 3'(k)) begin
                pr_n[k] = row_q;
                pc_n[k] = col_q;
            end
        end
`ifdef RECT_LOCATE_EARLY_EXIT_EN
        early_stop = hit && (cnt_q == 3'd4);
`else
        early_stop = 1'b0;
`endif
    end

    rect_corner_check #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_check (
        .p1_r (pr_n[0]),
        .p1_c (pc_n[0]),
        .p2_r (pr_n[1]),
        .p2_c (pc_n[1]),
        .p3_r (pr_n[2]),
        .p3_c (pc_n[2]),
        .p4_r (pr_n[3]),
        .p4_c (pc_n[3]),
        .cnt  (cnt_n),
        .err  (chk_err)
    );

    // Locator FSM: accept a pair, scan the difference, hold the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            diff_q      <= '0;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            pr_q        <= '{default: '0};
            pc_q        <= '{default: '0};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        diff_q     <= bus.a_in ^ bus.b_in;
                        idx_q      <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        cnt_q      <= '0;
                        pr_q       <= '{default: '0};
                        pc_q       <= '{default: '0};
                        in_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    cnt_q <= cnt_n;
                    pr_q  <= pr_n;
                    pc_q  <= pc_n;
                    idx_q <= idx_q + IW'(1);
                    if (col_q == CW'(COLS - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                    if (last_bit || early_stop) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        err_q       <= chk_err;
                        r1_q        <= chk_err ? '0 : pr_n[0];
                        c1_q        <= chk_err ? '0 : pc_n[0];
                        c2_q        <= chk_err ? '0 : pc_n[1];
                        r2_q        <= chk_err ? '0 : pr_n[2];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.r1        = r1_q;
    assign bus.r2        = r2_q;
    assign bus.c1        = c1_q;
    assign bus.c2        = c2_q;
    assign bus.state     = state_q;

endmodule
